d_branch_resolver: RTL and testbench
====================================

Name: d_branch_resolver

Overview:
- Decode-stage branch resolution unit for the 5-stage MIPS pipeline.
- Evaluates a parametrised set of branch conditions on forwarded operands in D.
- Holds a BHT_DEPTH-entry table of 2-bit saturating counters: F looks up a prediction, D resolves and updates it.
- Flags mispredictions so the hazard unit can flush F, and keeps saturating branch/mispredict statistics counters.

Parameters:
- WIDTH, 32, operand width for A/B compare.
- BHT_DEPTH, 64, number of predictor entries; power of two, 2..1024.
- IDX_LO, 2, lowest PC bit used in the table index (word-aligned PCs).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- F_pc  in  32  fetch PC, used for prediction lookup.
- F_pred_taken  out  1  prediction for F_pc: counter MSB.
- D_pc  in  32  PC of the instruction in D.
- D_A  in  WIDTH  forwarded rs value.
- D_B  in  WIDTH  forwarded rt value.
- D_cmp_op  in  4  condition select (encoding below).
- D_pred_taken  in  1  prediction carried through the F/D register.
- D_valid  in  1  D holds a real branch instruction.
- D_stall  in  1  D held this cycle by the hazard unit.
- D_cond  out  1  branch condition result (combinational).
- D_mispredict  out  1  D_cond != D_pred_taken on a valid, non-stalled branch.
- br_cnt  out  32  resolved-branch count, saturating.
- mp_cnt  out  32  misprediction count, saturating.

Behaviour:
- D_cmp_op encoding:
  - 0 EQ (A==B); 1 NE.
  - 2 LEZ, 3 GTZ, 4 LTZ, 5 GEZ: signed compare of A against 0; B ignored.
  - 6 LT (signed A<B); 7 LTU (unsigned A<B).
  - 8-15 reserved: D_cond=0 and the op counts as "not a branch".
- Resolve event: D_valid & !D_stall & op in 0..7.
- D_cond is purely combinational, with zero-cycle latency, like the existing equality path.
- D_mispredict = resolve & (D_cond ^ D_pred_taken). It is 0 whenever resolve is low.
- Table index: F index = F_pc[IDX_LO +: log2(BHT_DEPTH)]; D index uses the same slice of D_pc.
- F_pred_taken = bit[1] of the F-indexed entry. The read is asynchronous.
- Counter update on the rising edge when resolve is high:
  - taken: increment, saturating at 2'b11.
  - not taken: decrement, saturating at 2'b00.
- No update while D_stall is high, so a stalled branch updates exactly once, in the cycle it leaves D.
- Same index read by F and written by D in one cycle: F_pred_taken reflects the pre-update value (read-before-write). There is no bypass.
- br_cnt increments on each resolve; mp_cnt increments on each resolve with D_mispredict. Both hold at 32'hFFFF_FFFF.
- Reset (reset low, asynchronous):
  - every table entry becomes 2'b01 (weakly not-taken);
  - br_cnt = 0, mp_cnt = 0;
  - F_pred_taken therefore reads 0.
  - Reset asserted mid-cycle overrides any pending update. The first update after release takes effect at the first rising edge with reset high.
- Comparator arithmetic:
  - Signed compares use $signed on full WIDTH.
  - Zero compares use the sign bit and a zero-detect of D_A.
  - No overflow path exists because there is no subtraction; LT uses a direct signed compare.
- X on D_A/D_B with resolve low must not change state.

Decomposition:
- Shared package/header (used by the decoder, this block and the bench):
  - CMP_EQ..CMP_LTU localparams, 4-bit;
  - BHT_INIT = 2'b01.
- One combinational sub-module, branch_cond_eval (WIDTH param; ins A, B, op; out cond), holds the condition mux.
- The table and statistics counters stay in the top module.

Test Plan:
- After reset release: F_pc=0x3000 -> F_pred_taken=0; br_cnt=0, mp_cnt=0.
- Each op 0..7 with D_valid=1:
  - A=0xFFFF_FFFF, B=0x0000_0001 -> D_cond = {EQ 0, NE 1, LEZ 1, GTZ 0, LTZ 1, GEZ 0, LT 1, LTU 0}.
  - Op 9 -> D_cond 0, no counter change.
- Training: 2 consecutive resolves with taken, D_pc=0x3010 -> entry goes 01->10->11, F_pc=0x3010 predicts 1.
  - A 3rd taken stays 11; mp_cnt increments only on the first.
- Stall: D_stall=1 for 3 cycles with a valid taken branch -> no entry or br_cnt change. The release cycle causes exactly one update (br_cnt +1).
- Same-cycle hazard: F_pc==D_pc index, entry=01, taken resolve -> F_pred_taken=0 that cycle and 1 the next.
- Async reset pulse mid-training: counters and table return to init without a clock edge.
- Saturation: force br_cnt to 0xFFFF_FFFE, then 2 resolves -> holds 0xFFFF_FFFF.

Source files
------------

// File: rtl/d_branch_resolver_pkg.sv
// Shared compare-op encodings and predictor helpers
// for the decode-stage branch resolver.
package d_branch_resolver_pkg;

  localparam logic [3:0] CMP_EQ  = 4'd0;
  localparam logic [3:0] CMP_NE  = 4'd1;
  localparam logic [3:0] CMP_LEZ = 4'd2;
  localparam logic [3:0] CMP_GTZ = 4'd3;
  localparam logic [3:0] CMP_LTZ = 4'd4;
  localparam logic [3:0] CMP_GEZ = 4'd5;
  localparam logic [3:0] CMP_LT  = 4'd6;
  localparam logic [3:0] CMP_LTU = 4'd7;

  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic logic is_branch_op(
    input logic [3:0] op
  );
    return ~op[3];
  endfunction

  function automatic logic [1:0] bht_next(
    input logic [1:0] cur,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11)
        nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00)
        nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] cur
  );
    return (cur == 32'hFFFF_FFFF) ? cur : cur + 32'd1;
  endfunction

endpackage

// File: rtl/d_branch_resolver_cond.sv
// Combinational branch condition mux
// operating on forwarded D-stage operands.
module branch_cond_eval
  import d_branch_resolver_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             cond
);

  logic w_zero;
  logic w_neg;
  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_zero = ~|A;
  assign w_neg  = A[WIDTH-1];
  assign w_eq   = (A == B);
  assign w_lt   = ($signed(A) < $signed(B));
  assign w_ltu  = (A < B);

  // Zero compares need only sign and zero-detect; no subtractor.
  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      (op == CMP_EQ):  cond = w_eq;
      (op == CMP_NE):  cond = ~w_eq;
      (op == CMP_LEZ): cond = w_neg | w_zero;
      (op == CMP_GTZ): cond = ~w_neg & ~w_zero;
      (op == CMP_LTZ): cond = w_neg;
      (op == CMP_GEZ): cond = ~w_neg;
      (op == CMP_LT):  cond = w_lt;
      (op == CMP_LTU): cond = w_ltu;
      default:         cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_resolver.sv
// Decode-stage branch resolver: condition eval,
// 2-bit BHT predictor and saturating statistics.
module d_branch_resolver
  import d_branch_resolver_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_LO    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      F_pc,
  output logic             F_pred_taken,
  input  logic [31:0]      D_pc,
  input  logic [WIDTH-1:0] D_A,
  input  logic [WIDTH-1:0] D_B,
  input  logic [3:0]       D_cmp_op,
  input  logic             D_pred_taken,
  input  logic             D_valid,
  input  logic             D_stall,
  output logic             D_cond,
  output logic             D_mispredict,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mp_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       r_bht [BHT_DEPTH];
  logic [31:0]      r_br_cnt;
  logic [31:0]      r_mp_cnt;

  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_d_idx;
  logic             w_cond;
  logic             w_resolve;
  logic             w_mispredict;
  logic             w_unused_pc;

  assign w_f_idx     = F_pc[IDX_LO +: IDX_W];
  assign w_d_idx     = D_pc[IDX_LO +: IDX_W];
  assign w_unused_pc = ^{F_pc, D_pc};

  branch_cond_eval #(
    .WIDTH (WIDTH)
  ) u_cond (
    .A    (D_A),
    .B    (D_B),
    .op   (D_cmp_op),
    .cond (w_cond)
  );

  assign w_resolve    = D_valid & ~D_stall
                      & is_branch_op(D_cmp_op);
  assign w_mispredict = w_resolve
                      & (w_cond ^ D_pred_taken);

  assign D_cond       = w_cond;
  assign D_mispredict = w_mispredict;

  // Async read: same-cycle D write is not bypassed to F.
  assign F_pred_taken = r_bht[w_f_idx][1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        r_bht[i] <= BHT_INIT;
    end else if (w_resolve) begin
      r_bht[w_d_idx] <= bht_next(r_bht[w_d_idx], w_cond);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_resolve) begin
      r_br_cnt <= sat_inc32(r_br_cnt);
      if (w_mispredict)
        r_mp_cnt <= sat_inc32(r_mp_cnt);
    end
  end

  assign br_cnt = r_br_cnt;
  assign mp_cnt = r_mp_cnt;

endmodule

// File: tb/tb_d_branch_resolver.sv
// Directed scoreboard bench for d_branch_resolver.
module tb_d_branch_resolver;
  import d_branch_resolver_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_pc;
  logic        F_pred_taken;
  logic [31:0] D_pc;
  logic [31:0] D_A;
  logic [31:0] D_B;
  logic [3:0]  D_cmp_op;
  logic        D_pred_taken;
  logic        D_valid;
  logic        D_stall;
  logic        D_cond;
  logic        D_mispredict;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always #5 clk = ~clk;

  d_branch_resolver #(
    .WIDTH     (32),
    .BHT_DEPTH (64),
    .IDX_LO    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .F_pc         (F_pc),
    .F_pred_taken (F_pred_taken),
    .D_pc         (D_pc),
    .D_A          (D_A),
    .D_B          (D_B),
    .D_cmp_op     (D_cmp_op),
    .D_pred_taken (D_pred_taken),
    .D_valid      (D_valid),
    .D_stall      (D_stall),
    .D_cond       (D_cond),
    .D_mispredict (D_mispredict),
    .br_cnt       (br_cnt),
    .mp_cnt       (mp_cnt)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [1:0]  m_bht [64];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  task automatic expect_v(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic mcond(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    case (op)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return $signed(a) <= 0;
      4'd3:    return $signed(a) > 0;
      4'd4:    return $signed(a) < 0;
      4'd5:    return $signed(a) >= 0;
      4'd6:    return $signed(a) < $signed(b);
      4'd7:    return a < b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mpred(input logic [31:0] pc);
    return m_bht[pc[7:2]][1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_br = '0;
    m_mp = '0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(
    input string       nm,
    input logic [31:0] pc,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op,
    input logic        pred,
    input logic        valid,
    input logic        stall,
    input logic [31:0] fpc
  );
    logic c, res, mp;
    int   di;
    D_pc = pc; D_A = a; D_B = b; D_cmp_op = op;
    D_pred_taken = pred; D_valid = valid;
    D_stall = stall; F_pc = fpc;
    c   = mcond(a, b, op);
    res = valid & ~stall & (op < 4'd8);
    mp  = res & (c ^ pred);
    di  = int'(pc[7:2]);
    expect_v({nm, "_cond"}, {31'd0, c});
    expect_v({nm, "_mispredict"}, {31'd0, mp});
    expect_v({nm, "_fpred"}, {31'd0, mpred(fpc)});
    #2;
    check_v({31'd0, D_cond});
    check_v({31'd0, D_mispredict});
    check_v({31'd0, F_pred_taken});
    @(posedge clk);
    if (res) begin
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (mp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      if (c) m_bht[di] = (m_bht[di] == 2'b11) ? 2'b11 : m_bht[di] + 2'b01;
      else   m_bht[di] = (m_bht[di] == 2'b00) ? 2'b00 : m_bht[di] - 2'b01;
    end
    #1;
    expect_v({nm, "_br_cnt"}, m_br);
    expect_v({nm, "_mp_cnt"}, m_mp);
    check_v(br_cnt);
    check_v(mp_cnt);
  endtask

  initial begin
    reset = 1'b0;
    F_pc = 32'h3000; D_pc = '0; D_A = '0; D_B = '0;
    D_cmp_op = 4'd0; D_pred_taken = 1'b0;
    D_valid = 1'b0; D_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    step("rst", 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h3000);

    for (int op = 0; op < 8; op++)
      step($sformatf("op%0d", op), 32'h3100 + 32'(op * 4),
           32'hFFFF_FFFF, 32'h1, 4'(op), 1'b0, 1'b1, 1'b0, 32'h3000);
    step("op9", 32'h3200, 32'hFFFF_FFFF, 32'h1, 4'd9,
         1'b0, 1'b1, 1'b0, 32'h3000);
    step("ltz_pos", 32'h3204, 32'h7FFF_FFFF, 32'h0, CMP_LTZ,
         1'b0, 1'b1, 1'b0, 32'h3000);
    step("gtz_zero", 32'h3208, 32'h0, 32'h5, CMP_GTZ,
         1'b1, 1'b1, 1'b0, 32'h3000);
    step("ltu_big", 32'h320C, 32'h1, 32'h8000_0000, CMP_LTU,
         1'b0, 1'b1, 1'b0, 32'h3000);

    for (int k = 0; k < 3; k++)
      step($sformatf("train%0d", k), 32'h3010, 32'h5, 32'h5, CMP_EQ,
           mpred(32'h3010), 1'b1, 1'b0, 32'h3010);
    step("trained", 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h3010);

    for (int k = 0; k < 3; k++)
      step($sformatf("stall%0d", k), 32'h3020, 32'h1, 32'h2, CMP_NE,
           mpred(32'h3020), 1'b1, 1'b1, 32'h3020);
    step("stall_rel", 32'h3020, 32'h1, 32'h2, CMP_NE,
         mpred(32'h3020), 1'b1, 1'b0, 32'h3020);

    step("haz0", 32'h3030, 32'h9, 32'h9, CMP_EQ,
         mpred(32'h3030), 1'b1, 1'b0, 32'h3030);
    step("haz1", 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h3030);

    step("pre_rst", 32'h3040, 32'h3, 32'h3, CMP_EQ,
         mpred(32'h3040), 1'b1, 1'b0, 32'h3010);
    D_valid = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    expect_v("async_br_cnt", m_br);
    expect_v("async_mp_cnt", m_mp);
    expect_v("async_fpred", {31'd0, mpred(32'h3010)});
    check_v(br_cnt);
    check_v(mp_cnt);
    check_v({31'd0, F_pred_taken});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 32'h3010, 32'h1, 32'h1, CMP_EQ,
         mpred(32'h3010), 1'b1, 1'b0, 32'h3010);

    force dut.r_br_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_br_cnt;
    m_br = 32'hFFFF_FFFE;
    step("sat0", 32'h3050, 32'h2, 32'h1, CMP_LT,
         mpred(32'h3050), 1'b1, 1'b0, 32'h3050);
    step("sat1", 32'h3050, 32'h2, 32'h1, CMP_LT,
         mpred(32'h3050), 1'b1, 1'b0, 32'h3050);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
